// File: rtl/arbitro_escritura_reg_pkg.sv
// Shared types and constants for the register-bank write-port arbiter.
package arbitro_pkg;

    localparam int ANCHO_DATO = 32;
    localparam int ANCHO_REG  = 5;

    // Requester indices, also the encoding of the last-granted pointer.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic [ANCHO_REG-1:0]  num_reg;
        logic [ANCHO_DATO-1:0] dato;
    } entrada_t;

endpackage

// File: rtl/fifo_escritura.sv
// Small writeback FIFO; every slot's register number and valid bit are
// exposed so the owner can search for pending writes to a register.
module fifo_escritura
    import arbitro_pkg::*;
#(
    parameter int PROF = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  entrada_t                           entrada,
    output entrada_t                           cabeza,
    output logic                               full,
    output logic                               empty,
    output logic [PROF-1:0][ANCHO_REG-1:0]     regs,
    output logic [PROF-1:0]                    validos
);

    localparam int AW = (PROF > 1) ? $clog2(PROF) : 1;

    entrada_t          mem [PROF];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       cuenta_reg;
    logic [PROF-1:0]   valido_reg;
    logic              do_push;
    logic              do_pop;

    // No pass-through: a full FIFO refuses a push even if it pops this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full   = (cuenta_reg == (AW+1)'(PROF));
    assign empty  = (cuenta_reg == '0);
    assign cabeza = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= entrada;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cuenta_reg <= '0;
            valido_reg <= '0;
        end else begin
            // Push and pop never hit the same slot: equal pointers mean empty or full.
            if (do_push) begin
                valido_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg             <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                valido_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg             <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cuenta_reg <= cuenta_reg + (AW+1)'(1);
                2'b01:   cuenta_reg <= cuenta_reg - (AW+1)'(1);
                default: cuenta_reg <= cuenta_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < PROF; gi++) begin : g_regs
        assign regs[gi] = mem[gi].num_reg;
    end

    assign validos = valido_reg;

endmodule

// File: rtl/arbitro_escritura_reg.sv
// Round-robin arbiter sharing the register bank write port between ALU (A)
// and load (B) writeback FIFOs. Define ARB_FILTRO_CERO_EN to drop writes to $zero.
module arbitro_escritura_reg
    import arbitro_pkg::*;
#(
    parameter int PROF = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ValidA,
    input  logic [ANCHO_REG-1:0]   RegA,
    input  logic [ANCHO_DATO-1:0]  DatoA,
    output logic                   ReadyA,
    input  logic                   ValidB,
    input  logic [ANCHO_REG-1:0]   RegB,
    input  logic [ANCHO_DATO-1:0]  DatoB,
    output logic                   ReadyB,
    input  logic                   Stall,
    input  logic [ANCHO_REG-1:0]   QueryReg,
    output logic                   QueryHit,
    output logic [ANCHO_REG-1:0]   WriteReg,
    output logic [ANCHO_DATO-1:0]  WriteData,
    output logic                   Regwrite,
    output logic                   Pendiente
);

    logic                           full_a, full_b, empty_a, empty_b;
    logic                           push_a, push_b, pop_a, pop_b;
    entrada_t                       cabeza_a, cabeza_b;
    logic [PROF-1:0][ANCHO_REG-1:0] regs_a, regs_b;
    logic [PROF-1:0]                validos_a, validos_b;
    logic [PROF-1:0]                hit_a, hit_b;

    logic                           ultimo_reg, ultimo_next;
    logic                           regwrite_reg, regwrite_next;
    logic [ANCHO_REG-1:0]           write_reg_reg, write_reg_next;
    logic [ANCHO_DATO-1:0]          write_data_reg, write_data_next;

    assign ReadyA = !full_a;
    assign ReadyB = !full_b;

`ifdef ARB_FILTRO_CERO_EN
    // Accepted from the requester, but never stored: $zero is not writable.
    assign push_a = ValidA && ReadyA && (RegA != '0);
    assign push_b = ValidB && ReadyB && (RegB != '0);
`else
    assign push_a = ValidA && ReadyA;
    assign push_b = ValidB && ReadyB;
`endif

    fifo_escritura #(.PROF(PROF)) u_fifo_a (
        .clk     (clk),
        .reset   (reset),
        .push    (push_a),
        .pop     (pop_a),
        .entrada ('{num_reg: RegA, dato: DatoA}),
        .cabeza  (cabeza_a),
        .full    (full_a),
        .empty   (empty_a),
        .regs    (regs_a),
        .validos (validos_a)
    );

    fifo_escritura #(.PROF(PROF)) u_fifo_b (
        .clk     (clk),
        .reset   (reset),
        .push    (push_b),
        .pop     (pop_b),
        .entrada ('{num_reg: RegB, dato: DatoB}),
        .cabeza  (cabeza_b),
        .full    (full_b),
        .empty   (empty_b),
        .regs    (regs_b),
        .validos (validos_b)
    );

    // On a tie the requester not granted last time wins.
    always_comb begin
        pop_a           = 1'b0;
        pop_b           = 1'b0;
        ultimo_next     = ultimo_reg;
        regwrite_next   = 1'b0;
        write_reg_next  = write_reg_reg;
        write_data_next = write_data_reg;
        if (!Stall) begin
            if (!empty_a && (empty_b || ultimo_reg == REQ_B)) begin
                pop_a           = 1'b1;
                ultimo_next     = REQ_A;
                regwrite_next   = 1'b1;
                write_reg_next  = cabeza_a.num_reg;
                write_data_next = cabeza_a.dato;
            end else if (!empty_b) begin
                pop_b           = 1'b1;
                ultimo_next     = REQ_B;
                regwrite_next   = 1'b1;
                write_reg_next  = cabeza_b.num_reg;
                write_data_next = cabeza_b.dato;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ultimo_reg     <= REQ_B;
            regwrite_reg   <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else begin
            ultimo_reg     <= ultimo_next;
            regwrite_reg   <= regwrite_next;
            write_reg_reg  <= write_reg_next;
            write_data_reg <= write_data_next;
        end
    end

    assign Regwrite  = regwrite_reg;
    assign WriteReg  = write_reg_reg;
    assign WriteData = write_data_reg;

    // The popped entry leaves the FIFO at the grant edge, so it is not searched.
    for (genvar gi = 0; gi < PROF; gi++) begin : g_hit
        assign hit_a[gi] = validos_a[gi] && (regs_a[gi] == QueryReg);
        assign hit_b[gi] = validos_b[gi] && (regs_b[gi] == QueryReg);
    end

    assign QueryHit  = (|hit_a) || (|hit_b);
    assign Pendiente = !empty_a || !empty_b;

endmodule

// File: tb/tb_arbitro_escritura_reg.sv
// Directed bench for arbitro_escritura_reg with a queue-based reference model.
module tb_arbitro_escritura_reg;

    localparam int PROF = 2;
`ifdef ARB_FILTRO_CERO_EN
    localparam bit FILTRO = 1'b1;
`else
    localparam bit FILTRO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ValidA = 1'b0, ValidB = 1'b0, Stall = 1'b0;
    logic [4:0]  RegA = '0, RegB = '0, QueryReg = '0;
    logic [31:0] DatoA = '0, DatoB = '0;
    logic        ReadyA, ReadyB, QueryHit, Regwrite, Pendiente;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    int total = 0;
    int bad = 0;

    arbitro_escritura_reg #(.PROF(PROF)) dut (
        .clk       (clk),
        .reset     (reset),
        .ValidA    (ValidA),
        .RegA      (RegA),
        .DatoA     (DatoA),
        .ReadyA    (ReadyA),
        .ValidB    (ValidB),
        .RegB      (RegB),
        .DatoB     (DatoB),
        .ReadyB    (ReadyB),
        .Stall     (Stall),
        .QueryReg  (QueryReg),
        .QueryHit  (QueryHit),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Regwrite  (Regwrite),
        .Pendiente (Pendiente)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per requester, pointer to last granted side.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        qa[$], qb[$];
    ent_t        e;
    bit          m_ult, m_rw, ra, rb, hit;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    initial begin : modelo
        forever begin
            @(posedge clk);
            if (reset) begin
                qa.delete();
                qb.delete();
                m_rw = 1'b0;
                m_wreg = '0;
                m_wdata = '0;
                m_ult = 1'b1;
            end else begin
                ra = (qa.size() < PROF);
                rb = (qb.size() < PROF);
                m_rw = 1'b0;
                if (!Stall) begin
                    if (qa.size() != 0 && (qb.size() == 0 || m_ult)) begin
                        e = qa.pop_front();
                        m_rw = 1'b1; m_wreg = e.r; m_wdata = e.d; m_ult = 1'b0;
                    end else if (qb.size() != 0) begin
                        e = qb.pop_front();
                        m_rw = 1'b1; m_wreg = e.r; m_wdata = e.d; m_ult = 1'b1;
                    end
                end
                if (ValidA && ra && !(FILTRO && RegA == 5'd0)) qa.push_back('{RegA, DatoA});
                if (ValidB && rb && !(FILTRO && RegB == 5'd0)) qb.push_back('{RegB, DatoB});
            end
            @(negedge clk);
            hit = 1'b0;
            foreach (qa[k]) if (qa[k].r == QueryReg) hit = 1'b1;
            foreach (qb[k]) if (qb[k].r == QueryReg) hit = 1'b1;
            check("m_regwrite",  Regwrite,  m_rw);
            check("m_writereg",  WriteReg,  m_wreg);
            check("m_writedata", WriteData, m_wdata);
            check("m_readya",    ReadyA,    qa.size() < PROF);
            check("m_readyb",    ReadyB,    qb.size() < PROF);
            check("m_pendiente", Pendiente, (qa.size() + qb.size()) != 0);
            check("m_queryhit",  QueryHit,  hit);
            if (m_rw) $display("write reg=%0d data=%08h", m_wreg, m_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin : estimulo
        step();
        do_reset();
        check("rst_regwrite", Regwrite, 1'b0);
        check("rst_writereg", WriteReg, 5'd0);
        check("rst_ready", {ReadyA, ReadyB}, 2'b11);
        check("rst_pendiente", Pendiente, 1'b0);
        check("rst_queryhit", QueryHit, 1'b0);

        // Single push on A.
        ValidA = 1'b1; RegA = 5'd5; DatoA = 32'hDEADBEEF;
        step();
        ValidA = 1'b0;
        check("single_pend", Pendiente, 1'b1);
        step();
        check("single_rw", Regwrite, 1'b1);
        check("single_reg", WriteReg, 5'd5);
        check("single_data", WriteData, 32'hDEADBEEF);
        step();
        check("single_rw_off", Regwrite, 1'b0);
        check("single_pend_off", Pendiente, 1'b0);

        // Both requesters streaming: alternating grants, A first after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ValidA = 1'b1; RegA = 5'(1 + i);  DatoA = 32'hA000_0000 + 32'(i);
            ValidB = 1'b1; RegB = 5'(11 + i); DatoB = 32'hB000_0000 + 32'(i);
            step();
            if (i == 1) begin
                check("alt_first_a", WriteReg, 5'd1);
                check("alt_readyb_full", ReadyB, 1'b0);
            end
            if (i == 2) begin
                check("alt_then_b", WriteReg, 5'd11);
                check("alt_readya_full", ReadyA, 1'b0);
            end
            if (i == 3) check("alt_then_a", WriteData, 32'hA000_0001);
        end
        ValidA = 1'b0; ValidB = 1'b0;
        repeat (6) step();

        // Stall with both FIFOs full, then four back-to-back writes.
        do_reset();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ValidA = 1'b1; RegA = 5'(20 + i); DatoA = 32'h1000 + 32'(i);
            ValidB = 1'b1; RegB = 5'(25 + i); DatoB = 32'h2000 + 32'(i);
            step();
        end
        ValidA = 1'b0; ValidB = 1'b0;
        step();
        check("stall_rw", Regwrite, 1'b0);
        check("stall_ready", {ReadyA, ReadyB}, 2'b00);
        Stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_rw", Regwrite, 1'b1);
        end
        step();
        check("drain_done", Regwrite, 1'b0);

        // Query port.
        do_reset();
        ValidA = 1'b1; RegA = 5'd9; DatoA = 32'h99; QueryReg = 5'd9;
        step();
        ValidA = 1'b0;
        check("query_hit", QueryHit, 1'b1);
        step();
        check("query_pop_rw", Regwrite, 1'b1);
        check("query_pop_hit", QueryHit, 1'b0);
        ValidA = 1'b1; QueryReg = 5'd10;
        step();
        ValidA = 1'b0;
        check("query_miss", QueryHit, 1'b0);
        step();

        // Reset with three entries queued; valids held through reset.
        Stall = 1'b1;
        ValidA = 1'b1; RegA = 5'd3; ValidB = 1'b1; RegB = 5'd4;
        step();
        ValidB = 1'b0;
        step();
        ValidB = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; ValidA = 1'b0; ValidB = 1'b0; Stall = 1'b0;
        check("mid_rst_rw", Regwrite, 1'b0);
        check("mid_rst_pend", Pendiente, 1'b0);
        check("mid_rst_ready", {ReadyA, ReadyB}, 2'b11);
        ValidA = 1'b1; RegA = 5'd7; DatoA = 32'h77;
        ValidB = 1'b1; RegB = 5'd8; DatoB = 32'h88;
        step();
        ValidA = 1'b0; ValidB = 1'b0;
        step();
        check("tie_after_rst", WriteReg, 5'd7);
        repeat (2) step();

        // Write to register zero.
        ValidB = 1'b1; RegB = 5'd0; DatoB = 32'h1;
        step();
        ValidB = 1'b0;
        step();
`ifdef ARB_FILTRO_CERO_EN
        check("zero_rw", Regwrite, 1'b0);
        check("zero_pend", Pendiente, 1'b0);
`else
        check("zero_rw", Regwrite, 1'b1);
        check("zero_reg", WriteReg, 5'd0);
        check("zero_data", WriteData, 32'h1);
`endif
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_escritura_reg.md
# arbitro_escritura_reg

Shares the register bank's single write port (WriteReg/WriteData/Regwrite) between two writeback requesters: ALU results (A) and memory loads (B). Each requester pushes into its own small FIFO via valid/ready. A round-robin arbiter drains at most one entry per cycle into registered write-port outputs. A query port reports whether a register still has a queued write, so decode can stall dependent reads.

## Interface
Parameters:
- PROF, 2: FIFO depth per requester; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- ValidA  in  1  requester A has a write
- RegA  in  5  destination register, A
- DatoA  in  32  write data, A
- ReadyA  out  1  FIFO A not full
- ValidB, RegB, DatoB, ReadyB: same as A, for requester B
- Stall  in  1  freeze draining this cycle
- QueryReg  in  5  register to check for pending writes
- QueryHit  out  1  some queued entry (A or B) targets QueryReg
- WriteReg  out  5  registered, to bank
- WriteData  out  32  registered, to bank
- Regwrite  out  1  registered one-cycle write strobe, to bank
- Pendiente  out  1  either FIFO non-empty

## Operation
- Push: ValidX && ReadyX at a rising edge enqueues {RegX, DatoX} into FIFO X. ReadyX = !fullX; no pass-through, so a full FIFO refuses pushes even when it pops in the same cycle.
- Grant, when Stall=0: only one FIFO non-empty → grant it. Both non-empty → grant the FIFO not named by pointer Ultimo. Neither → no grant.
- On grant: pop head, register it to WriteReg/WriteData, Regwrite=1 next cycle, Ultimo ← granted index.
- No grant, or Stall=1: Regwrite=0 next cycle; WriteReg/WriteData hold their last values; Ultimo unchanged.
- Order within one requester is strict FIFO. No ordering is guaranteed between A and B.
- QueryHit: combinational OR over all valid entries of both FIFOs. The entry being presented on the outputs is no longer queued and does not count.
- Pendiente = !emptyA || !emptyB, combinational.

## Timing
- Reset: FIFOs emptied (pending writes discarded), Regwrite=0, WriteReg=0, WriteData=0, Ultimo=B (A wins the first tie), ReadyA=ReadyB=1, Pendiente=0, QueryHit=0.
- Latency: push at edge N → earliest Regwrite=1 in cycle N+1 (edge N+1 onward). The bank performs the write while Regwrite is high.
- Throughput: one write per cycle total; two per three cycles are unattainable for a single requester only if the other requester has entries queued.
- Reset asserted mid-operation overrides push, pop and grant in the same cycle.
- Simultaneous push and pop on a non-full FIFO: both happen, count unchanged.
- FIFO pointers wrap modulo PROF; count width is log2(PROF)+1.

## Configuration
- ARB_FILTRO_CERO_EN defined: a push with RegX=0 is acknowledged (ReadyX honoured) but not enqueued. It never produces Regwrite and never contributes to QueryHit; writes to $zero are discarded.
- Not defined: register 0 is treated like any other register. It is enqueued, written and reported by QueryHit.

## Structure
- Package arbitro_pkg holds:
  - constants ANCHO_DATO=32 and ANCHO_REG=5
  - constants REQ_A=0 and REQ_B=1
  - typedef entrada_t {reg[4:0], dato[31:0]}
- Sub-module fifo_escritura: parameterised PROF; push/pop/full/empty/head; exposes every entry's reg field and valid bit for the QueryHit compare. Instantiated twice.

## Test plan
- Single push A (reg 5, 0xDEADBEEF) after reset → next cycle Regwrite=1, WriteReg=5, WriteData=0xDEADBEEF; following cycle Regwrite=0, Pendiente=0.
- A and B both valid for four cycles with Stall=0 → grants alternate A,B,A,B,… Each requester's data arrives in push order, and ReadyA/ReadyB drop when their FIFO holds 2.
- Stall=1 with both FIFOs full → Regwrite stays 0 and ReadyA=ReadyB=0. Release Stall → four writes on four consecutive cycles.
- Push A reg 9, then QueryReg=9 → QueryHit=1 until the pop edge, 0 in the cycle Regwrite=1; QueryReg=10 → QueryHit=0 throughout.
- Push B reg 0 with value 0x1: with ARB_FILTRO_CERO_EN defined → no Regwrite and Pendiente stays 0; without it → Regwrite=1, WriteReg=0.
- Reset pulsed with 3 entries queued → next cycle Regwrite=0, Pendiente=0, and both Ready signals high; the next tie is granted to A.
